// File: rtl/spawn_scheduler.sv
// Paces falling-character spawns: samples the generator once per interval, allocates the
// lowest free table slot, issues a one-cycle table write and tracks slot occupancy/misses.
module spawn_scheduler #(
  parameter int SLOTS     = 8,
  parameter int SLOT_W    = 3,
  parameter int X_MAX     = 624,
  parameter int MIN_SPEED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              tick,
  input  logic [7:0]        interval,
  input  logic [22:0]       gen_ch,
  input  logic              release_valid,
  input  logic [SLOT_W-1:0] release_slot,
  output logic              wr_en,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [22:0]       wr_data,
  output logic [SLOTS-1:0]  active_mask,
  output logic [SLOT_W:0]   active_count,
  output logic              full,
  output logic [7:0]        miss_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SEARCH, ST_WRITE} state_t;

  localparam logic [3:0] MIN_SPD = MIN_SPEED[3:0];
  localparam logic [9:0] X_LIM   = X_MAX[9:0];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [22:0]       stage_q, stage_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [22:0]       wr_data_q, wr_data_d;
  logic [SLOTS-1:0]  mask_q, mask_d;
  logic [SLOT_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic [7:0]        miss_q, miss_d;

  logic [SLOTS-1:0]  rel_mask;
  logic [SLOTS-1:0]  eff_mask;
  logic              found;
  logic [SLOT_W-1:0] free_idx;
  logic [7:0]        ivl;
  logic [8:0]        cnt_inc;
  logic [3:0]        san_spd;
  logic [9:0]        san_x;
  logic [22:0]       san_data;

  assign san_spd  = (stage_q[22:19] == 4'd0) ? MIN_SPD : stage_q[22:19];
  assign san_x    = (stage_q[9:0] > X_LIM) ? X_LIM : stage_q[9:0];
  assign san_data = {san_spd, stage_q[18:10], san_x};

  always_comb begin
    rel_mask = '0;
    if (release_valid) rel_mask[release_slot] = 1'b1;
    eff_mask = mask_q & ~rel_mask;

    // Scan downwards so the last hit is the lowest free index.
    found    = 1'b0;
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!eff_mask[i]) begin
        found    = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    wr_slot_d = wr_slot_q;
    wr_data_d = wr_data_q;
    miss_d    = miss_q;
    ivl       = (interval == 8'd0) ? 8'd1 : interval;
    cnt_inc   = {1'b0, cnt_q} + 9'd1;

    // Set wins over a same-slot release, so it is applied last.
    mask_d = eff_mask;
    if (state_q == ST_WRITE) mask_d[wr_slot_q] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (cnt_inc >= {1'b0, ivl}) begin
            state_d = ST_SEARCH;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      ST_SEARCH: begin
        stage_d = gen_ch;
        if (found) begin
          state_d   = ST_WRITE;
          wr_slot_d = free_idx;
        end else begin
          state_d = enable ? ST_WAIT : ST_IDLE;
          if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        end
      end
      ST_WRITE: begin
        wr_data_d = san_data;
        state_d   = enable ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    count_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      count_d = count_d + (SLOT_W + 1)'(mask_d[i]);
    end
    full_d = &mask_d;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stage_q   <= '0;
      wr_slot_q <= '0;
      wr_data_q <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      wr_slot_q <= wr_slot_d;
      wr_data_q <= wr_data_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      full_q    <= full_d;
      miss_q    <= miss_d;
    end
  end

  // wr_data_q captures the value at the end of WRITE so the bus holds afterwards.
  assign wr_en        = (state_q == ST_WRITE);
  assign wr_slot      = wr_slot_q;
  assign wr_data      = wr_en ? san_data : wr_data_q;
  assign active_mask  = mask_q;
  assign active_count = count_q;
  assign full         = full_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: directed scenarios then random traffic, all outputs compared
// every cycle against a spawn-event reference model.
module tb_spawn_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, clear, tick, release_valid;
  logic [7:0]  interval;
  logic [22:0] gen_ch;
  logic [2:0]  release_slot;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [22:0] wr_data;
  logic [7:0]  active_mask;
  logic [3:0]  active_count;
  logic        full;
  logic [7:0]  miss_count;

  int errors = 0;
  int checks = 0;

  spawn_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .tick(tick),
    .interval(interval), .gen_ch(gen_ch), .release_valid(release_valid),
    .release_slot(release_slot), .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
    .active_mask(active_mask), .active_count(active_count), .full(full),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Reference model: slot table as an array of flags, spawn lifecycle as two pending stages.
  bit          m_live [8];
  int          m_miss;
  bit          m_armed, m_search, m_write;
  int          m_frames;
  int          m_wslot;
  logic [22:0] m_wdata, m_last;

  function automatic logic [22:0] sanitise(logic [22:0] g);
    logic [3:0] sp;
    logic [9:0] x;
    sp = (g[22:19] == 4'd0) ? 4'd1 : g[22:19];
    x  = (g[9:0] > 10'd624) ? 10'd624 : g[9:0];
    return {sp, g[18:10], x};
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_live[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = m_live[i];
    return m;
  endfunction

  always @(posedge clk) begin
    bit nxt_search, nxt_write;
    int slot, need;
    if (rst || clear) begin
      for (int i = 0; i < 8; i++) m_live[i] = 1'b0;
      m_miss = 0; m_armed = 0; m_search = 0; m_write = 0; m_frames = 0;
      m_wslot = 0; m_wdata = '0; m_last = '0;
    end else begin
      nxt_search = 0;
      nxt_write  = 0;
      if (release_valid) m_live[release_slot] = 1'b0;
      if (m_search) begin
        slot = -1;
        for (int i = 0; i < 8 && slot < 0; i++) if (!m_live[i]) slot = i;
        if (slot >= 0) begin
          nxt_write = 1;
          m_wslot   = slot;
          m_wdata   = sanitise(gen_ch);
        end else if (m_miss < 255) begin
          m_miss++;
        end
        m_armed  = enable;
        m_frames = 0;
      end else if (m_write) begin
        m_live[m_wslot] = 1'b1;
        m_last  = m_wdata;
        m_armed = enable;
      end else if (!m_armed) begin
        if (enable) begin
          m_armed  = 1;
          m_frames = 0;
        end
      end else if (!enable) begin
        m_armed = 0;
      end else if (tick) begin
        need = (interval == 8'd0) ? 1 : int'(interval);
        m_frames++;
        if (m_frames >= need) begin
          m_frames   = 0;
          nxt_search = 1;
        end
      end
      m_search = nxt_search;
      m_write  = nxt_write;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("wr_en", 32'(wr_en), 32'(m_write));
    check_eq("wr_slot", 32'(wr_slot), 32'(m_wslot));
    check_eq("wr_data", 32'(wr_data), 32'(m_write ? m_wdata : m_last));
    check_eq("active_mask", 32'(active_mask), 32'(m_mask()));
    check_eq("active_count", 32'(active_count), 32'(m_count()));
    check_eq("full", 32'(full), 32'(m_count() == 8));
    check_eq("miss_count", 32'(miss_count), 32'(m_miss));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Tick with interval 1; returns in the WRITE cycle (or the cycle after a missed SEARCH).
  task automatic tick_to_write();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; tick = 1'b0; interval = 8'd1;
    gen_ch = '0; release_valid = 1'b0; release_slot = '0;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    cyc();
    check_eq("reset_mask", 32'(active_mask), 32'h0);
    check_eq("reset_wr_data", 32'(wr_data), 32'h0);

    // Interval 3: write two cycles after the third tick.
    enable = 1'b1; interval = 8'd3; gen_ch = {4'd5, 9'd0, 10'd100};
    cyc();
    for (int t = 0; t < 3; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    check_eq("p1_wr_en", 32'(wr_en), 32'h1);
    check_eq("p1_wr_slot", 32'(wr_slot), 32'h0);
    check_eq("p1_wr_data", 32'(wr_data), 32'h280064);
    cyc();
    check_eq("p1_mask", 32'(active_mask), 32'h01);
    check_eq("p1_count", 32'(active_count), 32'h1);

    // Fill the table, then two misses.
    do_reset();
    interval = 8'd1; gen_ch = {4'd0, 9'd0, 10'd700};
    cyc();
    for (int s = 0; s < 10; s++) begin
      tick_to_write();
      if (s < 8) begin
        check_eq("p2_slot_order", 32'(wr_slot), 32'(s));
        check_eq("p2_sanitised", 32'(wr_data), {9'd0, 4'd1, 9'd0, 10'd624});
      end
      cyc(); cyc();
    end
    check_eq("p2_full", 32'(full), 32'h1);
    check_eq("p2_mask", 32'(active_mask), 32'hFF);
    check_eq("p2_miss", 32'(miss_count), 32'h2);

    // Release slot 5 during SEARCH on a full table.
    tick = 1'b1; cyc(); tick = 1'b0;
    release_valid = 1'b1; release_slot = 3'd5;
    cyc();
    release_valid = 1'b0;
    check_eq("p3_wr_en", 32'(wr_en), 32'h1);
    check_eq("p3_wr_slot", 32'(wr_slot), 32'h5);
    cyc();
    check_eq("p3_full", 32'(full), 32'h1);
    check_eq("p3_miss", 32'(miss_count), 32'h2);

    // Duplicate and no-op releases.
    do_reset();
    cyc();
    for (int s = 0; s < 4; s++) begin tick_to_write(); cyc(); end
    check_eq("p4_mask0", 32'(active_mask), 32'h0F);
    release_valid = 1'b1; release_slot = 3'd2; cyc();
    check_eq("p4_mask1", 32'(active_mask), 32'h0B);
    cyc();
    release_slot = 3'd6; cyc();
    release_valid = 1'b0;
    check_eq("p4_mask2", 32'(active_mask), 32'h0B);
    tick_to_write();
    check_eq("p4_reuse", 32'(wr_slot), 32'h2);
    cyc();

    // Drop enable during WRITE, then interval 0.
    tick_to_write();
    enable = 1'b0;
    cyc();
    for (int t = 0; t < 3; t++) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
    interval = 8'd0; enable = 1'b1;
    cyc();
    for (int t = 0; t < 2; t++) begin tick_to_write(); cyc(); end

    // Clear mid-SEARCH, then reset during WRITE.
    tick = 1'b1; cyc(); tick = 1'b0;
    clear = 1'b1; cyc(); clear = 1'b0;
    check_eq("p6_clr_wr_en", 32'(wr_en), 32'h0);
    check_eq("p6_clr_mask", 32'(active_mask), 32'h0);
    check_eq("p6_clr_miss", 32'(miss_count), 32'h0);
    cyc();
    tick_to_write();
    rst = 1'b1; cyc(); rst = 1'b0;
    check_eq("p6_rst_wr_en", 32'(wr_en), 32'h0);
    check_eq("p6_rst_wr_data", 32'(wr_data), 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      clear         = ($urandom_range(0, 199) == 0);
      enable        = ($urandom_range(0, 15) != 0);
      tick          = ($urandom_range(0, 2) == 0);
      interval      = 8'($urandom_range(0, 3));
      gen_ch        = 23'($urandom);
      release_valid = ($urandom_range(0, 5) == 0);
      release_slot  = 3'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
